// File: rtl/damq_memory_bank_pkg.sv
// Shared helpers for the DAMQ memory bank: width derivation and reservation arithmetic.
package damq_memory_bank_pkg;

    // Bits needed to index `value` items; never narrower than one bit.
    function automatic int clogb(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Slots still held back for a VC that has not yet used its full reservation.
    function automatic int reservation_owed(input int count, input int reserved);
        return (reserved > count) ? (reserved - count) : 0;
    endfunction

endpackage

// File: rtl/memory_bank_free_list.sv
// Free-slot list plus the next-pointer array that also links every VC queue.
module memory_bank_free_list
    import damq_memory_bank_pkg::*;
#(
    parameter int depth = 32,
    parameter int ptr_w = clogb(depth),
    parameter int cnt_w = clogb(depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc,
    output logic [ptr_w-1:0] alloc_slot,
    input  logic             release_en,
    input  logic [ptr_w-1:0] release_slot,
    input  logic             link_en,
    input  logic [ptr_w-1:0] link_from,
    input  logic [ptr_w-1:0] link_to,
    input  logic [ptr_w-1:0] lookup_slot,
    output logic [ptr_w-1:0] lookup_next,
    output logic [cnt_w-1:0] free_count
);

    logic [ptr_w-1:0] next_ptr [depth];
    logic [ptr_w-1:0] free_head;
    logic [ptr_w-1:0] free_tail;

    assign alloc_slot  = free_head;
    assign lookup_next = next_ptr[lookup_slot];

    // NOTE: the link array is reset because it encodes the initial ascending free list; flit data is not.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            free_head  <= '0;
            free_tail  <= ptr_w'(depth - 1);
            free_count <= cnt_w'(depth);
            for (int i = 0; i < depth; i++) begin
                next_ptr[i] <= ptr_w'((i + 1) % depth);
            end
        end else begin
            if (link_en) begin
                next_ptr[link_from] <= link_to;
            end
            // An empty free list has a stale tail, so only chain onto a live one.
            if (release_en && free_count != '0) begin
                next_ptr[free_tail] <= release_slot;
            end
            if (release_en) begin
                free_tail <= release_slot;
            end
            if (alloc) begin
                free_head <= (free_count == cnt_w'(1)) ? release_slot : next_ptr[free_head];
            end else if (release_en && free_count == '0) begin
                free_head <= release_slot;
            end
            free_count <= free_count + cnt_w'(release_en) - cnt_w'(alloc);
        end
    end

endmodule

// File: rtl/damq_memory_bank.sv
// Dynamically allocated multi-queue flit buffer: per-VC linked-list FIFOs sharing one
// memory array, with per-VC slot reservations and registered status/error outputs.
module damq_memory_bank
    import damq_memory_bank_pkg::*;
#(
    parameter int max_vc_number     = 4,
    parameter int memory_bank_depth = 32,
    parameter int memory_bank_width = 64,
    parameter int reserved_per_vc   = 1
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 write_enable,
    input  logic [clogb(max_vc_number)-1:0]                      vc_written_into,
    input  logic [memory_bank_width-1:0]                         flit_in,
    input  logic                                                 read_enable,
    input  logic [clogb(max_vc_number)-1:0]                      vc_read_from,
    output logic [memory_bank_width-1:0]                         flit_out,
    output logic                                                 flit_out_valid,
    output logic [max_vc_number-1:0]                             vc_empty,
    output logic [max_vc_number-1:0]                             vc_full,
    output logic [max_vc_number*clogb(memory_bank_depth+1)-1:0]  vc_count,
    output logic                                                 memory_bank_full,
    output logic                                                 memory_bank_empty,
    output logic                                                 write_error,
    output logic                                                 read_error
);

    localparam int PW = clogb(memory_bank_depth);
    localparam int CW = clogb(memory_bank_depth + 1);
    localparam int VW = clogb(max_vc_number);

    logic [memory_bank_width-1:0] flit_mem [memory_bank_depth];
    logic [PW-1:0] vc_head [max_vc_number];
    logic [PW-1:0] vc_tail [max_vc_number];
    logic [CW-1:0] vc_cnt  [max_vc_number];
    logic [CW-1:0] cnt_nxt [max_vc_number];

    logic [VW-1:0] wr_vc;
    logic [VW-1:0] rd_vc;
    logic          wr_acc;
    logic          rd_acc;
    logic          head_takes_alloc;
    logic [PW-1:0] alloc_slot;
    logic [PW-1:0] lookup_next;
    logic [CW-1:0] free_count;
    logic [CW-1:0] free_nxt;
    int            owed_nxt;
    logic [max_vc_number-1:0] empty_nxt;
    logic [max_vc_number-1:0] full_nxt;

    assign wr_vc = vc_written_into;
    assign rd_vc = vc_read_from;

    // Admission looks only at the registered flags, i.e. the state at the start of the cycle.
    assign wr_acc = write_enable && (int'(wr_vc) < max_vc_number) && !vc_full[wr_vc];
    assign rd_acc = read_enable && (int'(rd_vc) < max_vc_number) && !vc_empty[rd_vc];

    // A write becomes the head when its queue is empty or is being emptied by a same-VC read.
    assign head_takes_alloc = (vc_cnt[wr_vc] == '0) ||
                              (rd_acc && rd_vc == wr_vc && vc_cnt[wr_vc] == CW'(1));

    memory_bank_free_list #(
        .depth (memory_bank_depth),
        .ptr_w (PW),
        .cnt_w (CW)
    ) u_free_list (
        .clk          (clk),
        .reset        (reset),
        .alloc        (wr_acc),
        .alloc_slot   (alloc_slot),
        .release_en   (rd_acc),
        .release_slot (vc_head[rd_vc]),
        .link_en      (wr_acc && vc_cnt[wr_vc] != '0),
        .link_from    (vc_tail[wr_vc]),
        .link_to      (alloc_slot),
        .lookup_slot  (vc_head[rd_vc]),
        .lookup_next  (lookup_next),
        .free_count   (free_count)
    );

    // NOTE: every variable written here is given a default first so no latch is inferred.
    always_comb begin
        free_nxt = free_count;
        if (wr_acc) free_nxt = free_nxt - 1'b1;
        if (rd_acc) free_nxt = free_nxt + 1'b1;
        owed_nxt = 0;
        for (int v = 0; v < max_vc_number; v++) begin
            cnt_nxt[v] = vc_cnt[v];
            if (wr_acc && int'(wr_vc) == v) cnt_nxt[v] = cnt_nxt[v] + 1'b1;
            if (rd_acc && int'(rd_vc) == v) cnt_nxt[v] = cnt_nxt[v] - 1'b1;
            owed_nxt = owed_nxt + reservation_owed(int'(cnt_nxt[v]), reserved_per_vc);
        end
        for (int v = 0; v < max_vc_number; v++) begin
            empty_nxt[v] = (cnt_nxt[v] == '0);
            full_nxt[v]  = (int'(cnt_nxt[v]) >= reserved_per_vc) && (int'(free_nxt) == owed_nxt);
        end
    end

    // Flit storage carries no reset: stale slots are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            flit_mem[alloc_slot] <= flit_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < max_vc_number; v++) begin
                vc_head[v] <= '0;
                vc_tail[v] <= '0;
                vc_cnt[v]  <= '0;
            end
            flit_out          <= '0;
            flit_out_valid    <= 1'b0;
            write_error       <= 1'b0;
            read_error        <= 1'b0;
            vc_empty          <= '1;
            vc_full           <= '0;
            memory_bank_full  <= 1'b0;
            memory_bank_empty <= 1'b1;
        end else begin
            for (int v = 0; v < max_vc_number; v++) begin
                vc_cnt[v] <= cnt_nxt[v];
            end
            if (rd_acc) begin
                flit_out       <= flit_mem[vc_head[rd_vc]];
                vc_head[rd_vc] <= lookup_next;
            end
            // Placed after the read so a same-VC write at count 1 overrides the stale successor.
            if (wr_acc) begin
                vc_tail[wr_vc] <= alloc_slot;
                if (head_takes_alloc) begin
                    vc_head[wr_vc] <= alloc_slot;
                end
            end
            flit_out_valid    <= rd_acc;
            write_error       <= write_enable && !wr_acc;
            read_error        <= read_enable && !rd_acc;
            vc_empty          <= empty_nxt;
            vc_full           <= full_nxt;
            memory_bank_full  <= (free_nxt == '0);
            memory_bank_empty <= &empty_nxt;
        end
    end

    for (genvar g = 0; g < max_vc_number; g++) begin : g_count
        assign vc_count[(max_vc_number-1-g)*CW +: CW] = vc_cnt[g];
    end

    int slot_total;
    always_comb begin
        slot_total = int'(free_count);
        for (int v = 0; v < max_vc_number; v++) begin
            slot_total = slot_total + int'(vc_cnt[v]);
        end
    end

    // Every slot is either free or owned by exactly one VC.
    assert property (@(posedge clk) disable iff (!reset) slot_total == memory_bank_depth);

endmodule

// File: tb/tb_damq_memory_bank.sv
// Randomised scoreboard bench for damq_memory_bank against per-VC queue reference model.
module tb_damq_memory_bank;

    localparam int V  = 4;
    localparam int D  = 32;
    localparam int W  = 64;
    localparam int R  = 1;
    localparam int CW = 6;
    localparam int VW = 2;

    logic          clk;
    logic          reset;
    logic          write_enable;
    logic [VW-1:0] vc_written_into;
    logic [W-1:0]  flit_in;
    logic          read_enable;
    logic [VW-1:0] vc_read_from;
    logic [W-1:0]  flit_out;
    logic          flit_out_valid;
    logic [V-1:0]  vc_empty;
    logic [V-1:0]  vc_full;
    logic [V*CW-1:0] vc_count;
    logic          memory_bank_full;
    logic          memory_bank_empty;
    logic          write_error;
    logic          read_error;

    damq_memory_bank #(
        .max_vc_number     (V),
        .memory_bank_depth (D),
        .memory_bank_width (W),
        .reserved_per_vc   (R)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .write_enable      (write_enable),
        .vc_written_into   (vc_written_into),
        .flit_in           (flit_in),
        .read_enable       (read_enable),
        .vc_read_from      (vc_read_from),
        .flit_out          (flit_out),
        .flit_out_valid    (flit_out_valid),
        .vc_empty          (vc_empty),
        .vc_full           (vc_full),
        .vc_count          (vc_count),
        .memory_bank_full  (memory_bank_full),
        .memory_bank_empty (memory_bank_empty),
        .write_error       (write_error),
        .read_error        (read_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: one plain queue per VC, plus expected registered side outputs.
    logic [W-1:0] mq [V][$];
    logic [W-1:0] exp_flits [$];
    logic [W-1:0] m_last;
    bit           exp_valid, exp_werr, exp_rerr;

    task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic int m_free();
        int used = 0;
        for (int v = 0; v < V; v++) used += mq[v].size();
        return D - used;
    endfunction

    function automatic int m_shared();
        int owed = 0;
        for (int v = 0; v < V; v++) owed += (mq[v].size() < R) ? (R - mq[v].size()) : 0;
        return m_free() - owed;
    endfunction

    function automatic bit m_full(input int v);
        return (mq[v].size() >= R) && (m_shared() == 0);
    endfunction

    function automatic logic [CW-1:0] dut_count(input int v);
        return vc_count[(V-1-v)*CW +: CW];
    endfunction

    task automatic model_clear();
        for (int v = 0; v < V; v++) mq[v].delete();
        exp_flits.delete();
        m_last    = '0;
        exp_valid = 1'b0;
        exp_werr  = 1'b0;
        exp_rerr  = 1'b0;
    endtask

    task automatic check_status();
        bit all_empty = 1'b1;
        for (int v = 0; v < V; v++) begin
            check($sformatf("vc_empty[%0d]", v), W'(vc_empty[v]), W'(mq[v].size() == 0));
            check($sformatf("vc_full[%0d]", v), W'(vc_full[v]), W'(m_full(v)));
            check($sformatf("vc_count[%0d]", v), W'(dut_count(v)), W'(mq[v].size()));
            if (mq[v].size() != 0) all_empty = 1'b0;
        end
        check("memory_bank_full", W'(memory_bank_full), W'(m_free() == 0));
        check("memory_bank_empty", W'(memory_bank_empty), W'(all_empty));
        check("write_error", W'(write_error), W'(exp_werr));
        check("read_error", W'(read_error), W'(exp_rerr));
        check("flit_out_valid", W'(flit_out_valid), W'(exp_valid));
        check("flit_out_hold", flit_out, m_last);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_vc_empty"}, W'(vc_empty), W'(4'hf));
        check({tag, "_vc_full"}, W'(vc_full), '0);
        check({tag, "_vc_count"}, W'(vc_count), '0);
        check({tag, "_bank_empty"}, W'(memory_bank_empty), W'(1));
        check({tag, "_bank_full"}, W'(memory_bank_full), '0);
        check({tag, "_flit_out"}, flit_out, '0);
        check({tag, "_valid"}, W'(flit_out_valid), '0);
        check({tag, "_errors"}, W'({write_error, read_error}), '0);
    endtask

    // One clock cycle: inputs applied at a falling edge, model decides admission from
    // the same start-of-cycle state, outputs compared at the following falling edge.
    task automatic step(input bit we, input int wvc, input logic [W-1:0] din,
                        input bit re, input int rvc);
        bit w_ok, r_ok;
        write_enable    = we;
        vc_written_into = VW'(wvc);
        flit_in         = din;
        read_enable     = re;
        vc_read_from    = VW'(rvc);
        w_ok = we && !m_full(wvc);
        r_ok = re && (mq[rvc].size() != 0);
        if (r_ok) begin
            m_last = mq[rvc].pop_front();
            exp_flits.push_back(m_last);
        end
        if (w_ok) mq[wvc].push_back(din);
        exp_valid = r_ok;
        exp_werr  = we && !w_ok;
        exp_rerr  = re && !r_ok;
        @(negedge clk);
        write_enable = 1'b0;
        read_enable  = 1'b0;
        check_status();
    endtask

    task automatic drain();
        for (int v = 0; v < V; v++) begin
            for (int n = 0; n < D && mq[v].size() != 0; n++) step(0, 0, '0, 1, v);
        end
    endtask

    // Monitor: every presented flit must match the oldest expected read.
    initial begin
        forever begin
            @(negedge clk);
            if (reset && flit_out_valid) begin
                if (exp_flits.size() == 0) begin
                    check("unexpected_flit", flit_out, '0);
                    check("unexpected_flit_valid", W'(flit_out_valid), '0);
                end else begin
                    check("flit_data", flit_out, exp_flits.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        write_enable = 1'b0; vc_written_into = '0; flit_in = '0;
        read_enable = 1'b0;  vc_read_from = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clk);
        check_status();

        // Empty read at reset.
        step(0, 0, '0, 1, 3);
        check("empty_read_error", W'(read_error), W'(1));
        check("empty_read_valid", W'(flit_out_valid), '0);
        check("empty_read_flit_out", flit_out, '0);

        // Simple FIFO on VC2.
        for (int i = 1; i <= 4; i++) step(1, 2, W'(i), 0, 0);
        check("vc2_count_4", W'(dut_count(2)), W'(4));
        for (int i = 1; i <= 4; i++) step(0, 0, '0, 1, 2);
        check("vc2_empty_again", W'(vc_empty[2]), W'(1));
        check("vc2_count_0", W'(dut_count(2)), '0);

        // Fill VC0 into the shared pool, then use the other reservations.
        for (int i = 0; i < 29; i++) step(1, 0, W'(100 + i), 0, 0);
        check("vc0_full_after_29", W'(vc_full[0]), W'(1));
        check("others_not_full", W'(vc_full[3:1]), '0);
        for (int v = 1; v < V; v++) step(1, v, W'(200 + v), 0, 0);
        check("bank_full", W'(memory_bank_full), W'(1));
        step(1, 0, W'(999), 0, 0);
        check("vc0_overflow_error", W'(write_error), W'(1));
        drain();

        // Interleaved VCs are independent.
        step(1, 0, W'(64'hA0), 0, 0);
        step(1, 1, W'(64'hB0), 0, 0);
        step(1, 0, W'(64'hA1), 0, 0);
        step(1, 1, W'(64'hB1), 0, 0);
        step(0, 0, '0, 1, 1);
        check("interleave_b0", flit_out, W'(64'hB0));
        step(0, 0, '0, 1, 1);
        step(0, 0, '0, 1, 0);
        check("interleave_a0", flit_out, W'(64'hA0));
        step(0, 0, '0, 1, 0);
        check("interleave_empty", W'(memory_bank_empty), W'(1));

        // Same-cycle read and write on VC1 at count 1.
        step(1, 1, W'(64'h500), 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 1, W'(64'h501 + i), 1, 1);
            check("rw_vc1_count_1", W'(dut_count(1)), W'(1));
        end
        step(0, 0, '0, 1, 1);
        check("rw_vc1_last", flit_out, W'(64'h50a));

        // Randomised traffic, write-heavy then read-heavy.
        for (int i = 0; i < 500; i++) begin
            int wp = (i < 250) ? 80 : 35;
            step($urandom_range(99) < wp, $urandom_range(V-1), {$urandom, $urandom},
                 $urandom_range(99) < 50, $urandom_range(V-1));
        end
        drain();

        // Reset mid-traffic with 12 flits queued.
        for (int i = 0; i < 12; i++) step(1, i % V, {$urandom, $urandom}, 0, 0);
        check("queued_12", W'(m_free()), W'(D - 12));
        reset = 1'b0;
        #1;
        check_reset_values("mid_reset");
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("first_slot_after_reset", W'(dut.alloc_slot), '0);
        check_status();
        step(1, 1, W'(64'hABCD), 0, 0);
        step(0, 0, '0, 1, 1);
        check("post_reset_flit", flit_out, W'(64'hABCD));
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(1), $urandom_range(V-1), {$urandom, $urandom},
                 $urandom_range(1), $urandom_range(V-1));
        end
        drain();
        step(0, 0, '0, 0, 0);
        check("scoreboard_drained", W'(exp_flits.size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
